gravsim_regfile: RTL and testbench
==================================

Name: gravsim_regfile

Overview:
- Shared simulation register file and the write-side responder for the physics FSM.
- Host side: a simple memory-mapped read/write port used by the software driver to load constants and planet state and to start a step.
- FSM side: exposes the full word array as `datafile`, and accepts the FSM's multi-word write bursts (`FSM_we`, `ADDR1-6`, `DATA1-6`) and its accumulator-clear request.
- Owns the START/DONE handshake between host and FSM.

Parameters:
- NUM_WORDS, 114, number of 32-bit words.
- MAX_PLANETS, 10, planets per field block; planets are indexed 1..MAX_PLANETS.
- ADDR_W, 7, host address width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- AVL_READ  in  1  host read strobe.
- AVL_WRITE  in  1  host write strobe.
- AVL_ADDR  in  ADDR_W  host word address.
- AVL_WRITEDATA  in  32  host write data.
- AVL_READDATA  out  32  registered host read data.
- FSM_START  out  1  level; high while a step is requested or running.
- FSM_DONE  in  1  one-cycle pulse from the FSM at end of step.
- clear_accs  in  1  zero all ACC_X/Y/Z words this cycle.
- FSM_we  in  2  FSM write command.
- ADDR1..ADDR6  in  32 each  FSM write addresses.
- DATA1..DATA6  in  32 each  FSM write data.
- datafile  out  32 x NUM_WORDS  live register contents.

Behaviour:
- Word map:
  - Word 0: G. Word 1: NUM. Word 2: START. Word 3: DONE.
  - Per-planet fields, planet i in 1..10: MASS 3+i, RAD 13+i, POS_X 23+i, POS_Y 33+i, POS_Z 43+i, VEL_X 53+i, VEL_Y 63+i, VEL_Z 73+i, ACC_X 83+i, ACC_Y 93+i, ACC_Z 103+i.
- Reset:
  - All words are 0.
  - AVL_READDATA = 0.
  - FSM_START = 0.
  - The reset takes effect immediately (asynchronous); it may arrive mid-step, and the state after reset equals the post-reset state.
- datafile:
  - Driven directly from the registers.
  - A write on edge N is visible after edge N.
- FSM_START equals bit 0 of word 2.
- Host read:
  - 1-cycle latency: AVL_READDATA is valid on the edge after AVL_READ.
  - AVL_READDATA holds its value otherwise.
  - Address >= NUM_WORDS returns 0 (except as defined under Optional Feature).
  - Simultaneous read and write to the same address returns the old value.
- Host write:
  - Address >= NUM_WORDS: ignored.
  - While busy (word 2 bit 0 = 1), writes to words 0, 1 and >= 4 are ignored.
  - Write to word 2:
    - Stores {31'b0, WRITEDATA[0]}.
    - Writing 1 also clears word 3.
    - Writing 0 while busy aborts, i.e. drops FSM_START.
  - Write to word 3: any value clears word 3.
- FSM_DONE:
  - Clears word 2 and sets word 3 = 1 on the same edge.
  - Takes priority over a same-cycle host write to word 2 or 3.
  - Ignored when word 2 = 0.
- FSM writes, evaluated each cycle:
  - FSM_we = 00: no write.
  - FSM_we = 01: writes ADDR1..3 / DATA1..3.
  - FSM_we = 10: writes ADDR1..6 / DATA1..6.
  - FSM_we = 11: reserved, no write.
  - Any ADDRk >= NUM_WORDS, or ADDRk < 4: that port is dropped; the other ports still write.
  - Duplicate addresses within one command: the highest-numbered port wins.
  - FSM write beats a host write to the same word in the same cycle.
- clear_accs:
  - Zeroes words 84..113 on that edge.
  - A same-cycle FSM write to an ACC word wins over the clear.
  - Other words are unaffected.
- Priority, highest first: RESET > FSM write > clear_accs > FSM_DONE (words 2/3 only) > host write.

Optional Feature:
- Macro: GRAVSIM_WRITE_COUNT_EN.
- When defined:
  - A 32-bit counter increments once per cycle with FSM_we ∈ {01, 10}, wrapping at 2^32-1 to 0.
  - The counter is cleared by RESET and by a host write of 1 to word 2.
  - Host reads at address NUM_WORDS return the counter.
- When undefined: no counter; that address reads 0.

Test Plan:
- Reset, then host read of word 0 and word 113 -> both 0; FSM_START = 0 → verifies the reset state.
- Host writes word 0 = 32'h40800000, word 1 = 2, then word 2 = 1 -> FSM_START = 1 the next cycle, and word 0 = 32'h40800000 on datafile.
- While busy, host writes word 24 = 32'h3f800000 -> ignored, word 24 stays 0.
- FSM_we = 10, ADDR1..6 = 24, 25, 34, 35, 2, 24, DATA1..6 = 32'h3f800000, 32'hbf800000, 1, 2, 9, 7 -> the words are written as follows:
  - Word 24 = 7 (port 6 beats port 1).
  - Word 25 = 32'hbf800000.
  - Word 34 = 1, word 35 = 2.
  - Word 2 unchanged (ADDR < 4 dropped).
- ACC_Z of planet 1 (word 104) = 32'h3f800000, then clear_accs with FSM_we = 01, ADDR1 = 85, DATA1 = 5 -> word 104 = 0, word 85 = 5.
- FSM_DONE pulse in the same cycle as a host write of 1 to word 3 -> word 2 = 0, word 3 = 1, FSM_START falls. Then host write word 3 -> word 3 = 0.
- RESET asserted mid-step -> all words and FSM_START are 0 before the next edge.

Source files
------------

// File: rtl/gravsim_regfile.sv
// ---------------------------------------------------------------------------
// gravsim_regfile
//
// Shared register file for the gravity simulator. The host loads constants
// and planet state through a simple memory-mapped port and kicks off a step
// by writing 1 to the START word. The physics FSM sees every word at once on
// `datafile`, writes results back in bursts of 3 or 6 words, clears the
// acceleration accumulators, and ends a step with a FSM_DONE pulse.
//
// Word map (planet i = 1..MAX_PLANETS):
//   0 G, 1 NUM, 2 START, 3 DONE,
//   MASS 3+i, RAD 13+i, POS_X/Y/Z 23+i/33+i/43+i,
//   VEL_X/Y/Z 53+i/63+i/73+i, ACC_X/Y/Z 83+i/93+i/103+i
//
// Ports:
//   CLK, RESET           clock, asynchronous active-high reset
//   AVL_READ/AVL_WRITE   host strobes
//   AVL_ADDR             host word address
//   AVL_WRITEDATA        host write data
//   AVL_READDATA         registered host read data (1-cycle latency, held)
//   FSM_START            bit 0 of word 2; high while a step is requested/running
//   FSM_DONE             one-cycle end-of-step pulse from the FSM
//   clear_accs           zero all ACC_X/Y/Z words this cycle
//   FSM_we               00 none, 01 ports 1..3, 10 ports 1..6, 11 reserved
//   ADDR1..6, DATA1..6   FSM write ports
//   datafile             live contents of every word
//
// Priority per word, highest first:
//   RESET > FSM write > clear_accs > FSM_DONE (words 2/3) > host write
//
// Optional build macro GRAVSIM_WRITE_COUNT_EN: adds a 32-bit count of cycles
// carrying an FSM write command, readable at host address NUM_WORDS and
// cleared when the host starts a step. Without it that address reads 0.
// ---------------------------------------------------------------------------
module gravsim_regfile #(
    parameter int NUM_WORDS   = 114,
    parameter int MAX_PLANETS = 10,
    parameter int ADDR_W      = 7
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        AVL_READ,
    input  logic                        AVL_WRITE,
    input  logic [ADDR_W-1:0]           AVL_ADDR,
    input  logic [31:0]                 AVL_WRITEDATA,
    output logic [31:0]                 AVL_READDATA,
    output logic                        FSM_START,
    input  logic                        FSM_DONE,
    input  logic                        clear_accs,
    input  logic [1:0]                  FSM_we,
    input  logic [31:0]                 ADDR1,
    input  logic [31:0]                 ADDR2,
    input  logic [31:0]                 ADDR3,
    input  logic [31:0]                 ADDR4,
    input  logic [31:0]                 ADDR5,
    input  logic [31:0]                 ADDR6,
    input  logic [31:0]                 DATA1,
    input  logic [31:0]                 DATA2,
    input  logic [31:0]                 DATA3,
    input  logic [31:0]                 DATA4,
    input  logic [31:0]                 DATA5,
    input  logic [31:0]                 DATA6,
    output logic [NUM_WORDS-1:0][31:0]  datafile
);

    localparam logic [31:0]       NUM_WORDS_W = 32'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] START_ADDR  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] DONE_ADDR   = ADDR_W'(3);
    // ACC_X/Y/Z occupy the last three planet field blocks.
    localparam int                ACC_FIRST   = 4 + 8 * MAX_PLANETS;
    localparam int                ACC_LAST    = ACC_FIRST + 3 * MAX_PLANETS - 1;

    logic [NUM_WORDS-1:0][31:0] words;
    logic [NUM_WORDS-1:0][31:0] words_next;
    logic [31:0]                fsm_addr [6];
    logic [31:0]                fsm_data [6];
    logic [2:0]                 fsm_ports;
    logic                       busy;
    logic                       host_in_range;
    logic                       host_start;
    logic [31:0]                read_extra;
    logic [31:0]                read_value;

    assign fsm_addr[0] = ADDR1;
    assign fsm_addr[1] = ADDR2;
    assign fsm_addr[2] = ADDR3;
    assign fsm_addr[3] = ADDR4;
    assign fsm_addr[4] = ADDR5;
    assign fsm_addr[5] = ADDR6;
    assign fsm_data[0] = DATA1;
    assign fsm_data[1] = DATA2;
    assign fsm_data[2] = DATA3;
    assign fsm_data[3] = DATA4;
    assign fsm_data[4] = DATA5;
    assign fsm_data[5] = DATA6;

    assign busy          = words[2][0];
    assign host_in_range = 32'(AVL_ADDR) < NUM_WORDS_W;
    assign host_start    = AVL_WRITE && (AVL_ADDR == START_ADDR) && AVL_WRITEDATA[0];

    assign datafile  = words;
    assign FSM_START = words[2][0];

    always_comb begin
        case (FSM_we)
            2'b01:   fsm_ports = 3'd3;
            2'b10:   fsm_ports = 3'd6;
            default: fsm_ports = 3'd0;   // 00 idle, 11 reserved
        endcase
    end

    // Next-state is built lowest priority first so each later stage overrides
    // the earlier ones for the words it touches.
    always_comb begin
        // NOTE: start from the current contents so every path assigns every
        // bit; a missing default here would infer latches.
        words_next = words;

        // Host write. START/DONE stay writable while busy so the host can
        // abort a step or acknowledge completion.
        if (AVL_WRITE && host_in_range) begin
            if (AVL_ADDR == START_ADDR) begin
                words_next[2] = {31'b0, AVL_WRITEDATA[0]};
                if (AVL_WRITEDATA[0]) begin
                    words_next[3] = '0;
                end
            end else if (AVL_ADDR == DONE_ADDR) begin
                words_next[3] = '0;
            end else if (!busy) begin
                words_next[AVL_ADDR] = AVL_WRITEDATA;
            end
        end

        // End of step: only meaningful while a step is running.
        if (FSM_DONE && busy) begin
            words_next[2] = '0;
            words_next[3] = 32'd1;
        end

        if (clear_accs) begin
            for (int i = ACC_FIRST; i <= ACC_LAST; i++) begin
                words_next[i] = '0;
            end
        end

        // Ascending port order lets the highest-numbered duplicate win. Ports
        // aimed at the control words or outside the array are dropped.
        for (int k = 0; k < 6; k++) begin
            if ((3'(k) < fsm_ports) && (fsm_addr[k] >= 32'd4) &&
                (fsm_addr[k] < NUM_WORDS_W)) begin
                words_next[fsm_addr[k][ADDR_W-1:0]] = fsm_data[k];
            end
        end
    end

`ifdef GRAVSIM_WRITE_COUNT_EN
    logic [31:0] write_count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            write_count <= '0;
        end else if (host_start) begin
            write_count <= '0;
        end else if (fsm_ports != 3'd0) begin
            write_count <= write_count + 32'd1;   // wraps naturally
        end
    end

    assign read_extra = (32'(AVL_ADDR) == NUM_WORDS_W) ? write_count : '0;
`else
    assign read_extra = '0;
`endif

    // Reads sample the registers before this edge's update, so a same-cycle
    // write to the same address returns the old value.
    assign read_value = host_in_range ? words[AVL_ADDR] : read_extra;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // NOTE: the word array is built from flops, not a RAM macro, so it
            // can and must be cleared by reset.
            words        <= '0;
            AVL_READDATA <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            words <= words_next;
            if (AVL_READ) begin
                AVL_READDATA <= read_value;
            end
        end
    end

endmodule

// File: tb/tb_gravsim_regfile.sv
// ---------------------------------------------------------------------------
// tb_gravsim_regfile
//
// Directed bench for gravsim_regfile: a table of single-cycle vectors with
// hand-computed expectations, followed by a hand-written mid-step reset
// sequence that checks the asynchronous clear between clock edges.
// ---------------------------------------------------------------------------
module tb_gravsim_regfile;

    localparam int NUM_WORDS = 114;

    logic                       CLK;
    logic                       RESET;
    logic                       AVL_READ;
    logic                       AVL_WRITE;
    logic [6:0]                 AVL_ADDR;
    logic [31:0]                AVL_WRITEDATA;
    logic [31:0]                AVL_READDATA;
    logic                       FSM_START;
    logic                       FSM_DONE;
    logic                       clear_accs;
    logic [1:0]                 FSM_we;
    logic [5:0][31:0]           fa;
    logic [5:0][31:0]           fd;
    logic [NUM_WORDS-1:0][31:0] datafile;

    int checks = 0;
    int errors = 0;

    gravsim_regfile dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .AVL_READ      (AVL_READ),
        .AVL_WRITE     (AVL_WRITE),
        .AVL_ADDR      (AVL_ADDR),
        .AVL_WRITEDATA (AVL_WRITEDATA),
        .AVL_READDATA  (AVL_READDATA),
        .FSM_START     (FSM_START),
        .FSM_DONE      (FSM_DONE),
        .clear_accs    (clear_accs),
        .FSM_we        (FSM_we),
        .ADDR1         (fa[0]),
        .ADDR2         (fa[1]),
        .ADDR3         (fa[2]),
        .ADDR4         (fa[3]),
        .ADDR5         (fa[4]),
        .ADDR6         (fa[5]),
        .DATA1         (fd[0]),
        .DATA2         (fd[1]),
        .DATA3         (fd[2]),
        .DATA4         (fd[3]),
        .DATA5         (fd[4]),
        .DATA6         (fd[5]),
        .datafile      (datafile)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string            name;
        logic             rd;
        logic             wr;
        logic [6:0]       addr;
        logic [31:0]      wdata;
        logic             done;
        logic             clr;
        logic [1:0]       we;
        logic [5:0][31:0] a;
        logic [5:0][31:0] d;
        logic             exp_start;
        logic             chk_rd;
        logic [31:0]      exp_rd;
        int               chk_idx;     // -1: no datafile check
        logic [31:0]      exp_word;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic [6:0] addr, input logic [31:0] wdata,
                                input logic done, input logic clr, input logic [1:0] we,
                                input logic exp_start, input logic chk_rd,
                                input logic [31:0] exp_rd, input int chk_idx,
                                input logic [31:0] exp_word);
        vec_t t;
        t.name = name;   t.rd = rd;     t.wr = wr;      t.addr = addr;
        t.wdata = wdata; t.done = done; t.clr = clr;    t.we = we;
        t.a = '0;        t.d = '0;
        t.exp_start = exp_start; t.chk_rd = chk_rd; t.exp_rd = exp_rd;
        t.chk_idx = chk_idx;     t.exp_word = exp_word;
        return t;
    endfunction

    task automatic set_idle();
        AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_ADDR = '0; AVL_WRITEDATA = '0;
        FSM_DONE = 1'b0; clear_accs = 1'b0; FSM_we = 2'b00; fa = '0; fd = '0;
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next
    // falling edge.
    task automatic apply(input vec_t t);
        AVL_READ = t.rd; AVL_WRITE = t.wr; AVL_ADDR = t.addr; AVL_WRITEDATA = t.wdata;
        FSM_DONE = t.done; clear_accs = t.clr; FSM_we = t.we; fa = t.a; fd = t.d;
        @(posedge CLK);
        @(negedge CLK);
        check({t.name, " start"}, 32'(FSM_START), 32'(t.exp_start));
        if (t.chk_rd) check({t.name, " rdata"}, AVL_READDATA, t.exp_rd);
        if (t.chk_idx >= 0) check({t.name, " word"}, datafile[t.chk_idx], t.exp_word);
    endtask

    vec_t vecs[$];
    vec_t t;
    logic [31:0] cnt_exp;
    int nonzero;

    initial begin
`ifdef GRAVSIM_WRITE_COUNT_EN
        cnt_exp = 32'd4;   // burst6, acc_set, clr_acc, drop_oob since the start write
`else
        cnt_exp = 32'd0;
`endif
        //              name          rd wr addr  wdata         dn cl we     st crd exp_rd        idx exp_word
        vecs.push_back(mk("rd_w0",     1, 0, 0,   0,            0, 0, 2'b00, 0, 1, 0,            -1, 0));
        vecs.push_back(mk("rd_w113",   1, 0, 113, 0,            0, 0, 2'b00, 0, 1, 0,            -1, 0));
        vecs.push_back(mk("wr_g",      0, 1, 0,   32'h40800000, 0, 0, 2'b00, 0, 0, 0,             0, 32'h40800000));
        vecs.push_back(mk("wr_num",    0, 1, 1,   2,            0, 0, 2'b00, 0, 0, 0,             1, 2));
        vecs.push_back(mk("start",     0, 1, 2,   1,            0, 0, 2'b00, 1, 0, 0,             0, 32'h40800000));
        vecs.push_back(mk("busy_wr",   0, 1, 24,  32'h3f800000, 0, 0, 2'b00, 1, 0, 0,            24, 0));
        t = mk("burst6",               0, 0, 0,   0,            0, 0, 2'b10, 1, 0, 0,            24, 7);
        t.a[0] = 24; t.a[1] = 25; t.a[2] = 34; t.a[3] = 35; t.a[4] = 2; t.a[5] = 24;
        t.d[0] = 32'h3f800000; t.d[1] = 32'hbf800000; t.d[2] = 1; t.d[3] = 2; t.d[4] = 9; t.d[5] = 7;
        vecs.push_back(t);
        vecs.push_back(mk("burst_25",  1, 0, 25,  0,            0, 0, 2'b00, 1, 1, 32'hbf800000, 34, 1));
        vecs.push_back(mk("burst_35",  1, 0, 35,  0,            0, 0, 2'b00, 1, 1, 2,             2, 1));
        t = mk("acc_set",              0, 0, 0,   0,            0, 0, 2'b01, 1, 0, 0,           104, 32'h3f800000);
        t.a[0] = 104; t.d[0] = 32'h3f800000;
        vecs.push_back(t);
        t = mk("clr_acc",              0, 0, 0,   0,            0, 1, 2'b01, 1, 0, 0,           104, 0);
        t.a[0] = 85; t.d[0] = 5;
        vecs.push_back(t);
        vecs.push_back(mk("rd_85",     1, 0, 85,  0,            0, 0, 2'b00, 1, 1, 5,            85, 5));
        t = mk("we_rsv",               0, 0, 0,   0,            0, 0, 2'b11, 1, 0, 0,            50, 0);
        t.a[0] = 50; t.d[0] = 99;
        vecs.push_back(t);
        t = mk("drop_oob",             0, 0, 0,   0,            0, 0, 2'b01, 1, 0, 0,            60, 32'h55);
        t.a[0] = 200; t.d[0] = 1; t.a[1] = 60; t.d[1] = 32'h55; t.a[2] = 3; t.d[2] = 7;
        vecs.push_back(t);
        vecs.push_back(mk("rd_w3",     1, 0, 3,   0,            0, 0, 2'b00, 1, 1, 0,             2, 1));
        vecs.push_back(mk("rd_114",    1, 0, 114, 0,            0, 0, 2'b00, 1, 1, cnt_exp,      -1, 0));
        vecs.push_back(mk("rd_120",    1, 0, 120, 0,            0, 0, 2'b00, 1, 1, 0,            -1, 0));
        vecs.push_back(mk("done_w3",   0, 1, 3,   1,            1, 0, 2'b00, 0, 0, 0,             3, 1));
        vecs.push_back(mk("rd_w2",     1, 0, 2,   0,            0, 0, 2'b00, 0, 1, 0,             3, 1));
        vecs.push_back(mk("clr_done",  0, 1, 3,   0,            0, 0, 2'b00, 0, 0, 0,             3, 0));
        vecs.push_back(mk("done_idle", 0, 0, 0,   0,            1, 0, 2'b00, 0, 0, 0,             3, 0));
        vecs.push_back(mk("idle_wr",   0, 1, 24,  32'h1234,     0, 0, 2'b00, 0, 0, 0,            24, 32'h1234));
        vecs.push_back(mk("rdwr_same", 1, 1, 24,  32'habcd,     0, 0, 2'b00, 0, 1, 32'h1234,     24, 32'habcd));
        t = mk("fsm_vs_host",          0, 1, 24,  32'h22,       0, 0, 2'b01, 0, 0, 0,            24, 32'h11);
        t.a[0] = 24; t.d[0] = 32'h11;
        vecs.push_back(t);
        vecs.push_back(mk("rd_24",     1, 0, 24,  0,            0, 0, 2'b00, 0, 1, 32'h11,       -1, 0));
        vecs.push_back(mk("rd_hold",   0, 0, 0,   0,            0, 0, 2'b00, 0, 1, 32'h11,       -1, 0));
        vecs.push_back(mk("restart",   0, 1, 2,   1,            0, 0, 2'b00, 1, 0, 0,             3, 0));
        vecs.push_back(mk("abort",     0, 1, 2,   0,            0, 0, 2'b00, 0, 0, 0,             2, 0));

        set_idle();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check("reset start", 32'(FSM_START), 32'd0);
        RESET = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);
        set_idle();

        // Mid-step asynchronous reset: start a step, land an FSM write, then
        // raise RESET between edges and check before any further edge.
        AVL_WRITE = 1'b1; AVL_ADDR = 7'd2; AVL_WRITEDATA = 32'd1;
        @(posedge CLK);
        @(negedge CLK);
        set_idle();
        FSM_we = 2'b01; fa[0] = 32'd30; fd[0] = 32'hdead;
        @(posedge CLK);
        #2;
        check("pre_rst start", 32'(FSM_START), 32'd1);
        check("pre_rst word30", datafile[30], 32'hdead);
        RESET = 1'b1;
        #1;
        check("rst start", 32'(FSM_START), 32'd0);
        check("rst rdata", AVL_READDATA, 32'd0);
        nonzero = 0;
        for (int i = 0; i < NUM_WORDS; i++) if (datafile[i] != 32'd0) nonzero++;
        check("rst nonzero_words", 32'(nonzero), 32'd0);
        @(negedge CLK);
        set_idle();
        RESET = 1'b0;
        apply(mk("post_rst_rd", 1, 0, 30, 0, 0, 0, 2'b00, 0, 1, 0, 2, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
